multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/seq_pkg.sv | 52 +++++
 rtl/seq_decoder.sv | 39 +++
 rtl/multicycle_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the multicycle sequencer: state encodings, opcode/funct
// values, exception cause codes and the decoded instruction class.
package seq_pkg;

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_MEMORY    = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_WAIT_FU   = 3'd5;
  localparam logic [2:0] ST_EXCEPTION = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;

  localparam logic [1:0] EXC_ILLEGAL = 2'd0;
  localparam logic [1:0] EXC_OVF     = 2'd1;
  localparam logic [1:0] EXC_DIV0    = 2'd2;
  localparam logic [1:0] EXC_FU_TO   = 2'd3;

  typedef enum logic [3:0] {
    CLS_ILLEGAL,
    CLS_J,
    CLS_JAL,
    CLS_ALU,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_MULT,
    CLS_DIV
  } instr_cls_e;

  // ovf_chk marks the signed arithmetic ops whose overflow traps.
  typedef struct packed {
    instr_cls_e cls;
    logic       ovf_chk;
  } decode_t;

endpackage

// File: rtl/seq_decoder.sv
// Combinational opcode/funct to instruction-class decoder.
module seq_decoder
  import seq_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output decode_t    dec
);

  always_comb begin
    dec.cls     = CLS_ILLEGAL;
    dec.ovf_chk = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB: begin
            dec.cls     = CLS_ALU;
            dec.ovf_chk = 1'b1;
          end
          FN_AND, FN_OR, FN_SLT: dec.cls = CLS_ALU;
          FN_MULT:               dec.cls = CLS_MULT;
          FN_DIV:                dec.cls = CLS_DIV;
          default:               dec.cls = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        dec.cls     = CLS_ALU;
        dec.ovf_chk = 1'b1;
      end
      OP_J:    dec.cls = CLS_J;
      OP_JAL:  dec.cls = CLS_JAL;
      OP_BEQ:  dec.cls = CLS_BEQ;
      OP_LW:   dec.cls = CLS_LW;
      OP_SW:   dec.cls = CLS_SW;
      default: dec.cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control sequencer: state register, per-state dwell counter,
// exception cause latch and the single-cycle control strobes.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int FU_TIMEOUT = 34,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic [31:0]      instruction,
  input  logic             zero_flag,
  input  logic             overflow_flag,
  input  logic             div_zero,
  input  logic             fu_done,
  input  logic             stall,
  output logic [2:0]       current_state,
  output logic [CNT_W-1:0] counter,
  output logic             pc_write_enable,
  output logic             instruction_write,
  output logic             memory_write,
  output logic             register_write,
  output logic             fu_start,
  output logic             exception_valid,
  output logic [1:0]       exception_control
);

  localparam int MAX_CNT = (MEM_LAT > FU_TIMEOUT) ? MEM_LAT : FU_TIMEOUT;
  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] FU_LAST  = CNT_W'(FU_TIMEOUT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("MEM_LAT must be in 1..15");
  end
  if (FU_TIMEOUT < 1) begin : g_bad_timeout
    $error("FU_TIMEOUT must be at least 1");
  end
  if ((2 ** CNT_W) <= MAX_CNT) begin : g_bad_cnt_w
    $error("CNT_W too narrow for MEM_LAT/FU_TIMEOUT");
  end

  logic [2:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       exc_code_q;
  logic [2:0]       next_st;
  logic             set_exc;
  logic [1:0]       exc_code_d;
  logic             pc_we_c, ir_we_c, mw_c, rw_c, fs_c;
  logic             active;
  decode_t          dec;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^instruction[25:6];

  seq_decoder u_decoder (
    .opcode (instruction[31:26]),
    .funct  (instruction[5:0]),
    .dec    (dec)
  );

  always_comb begin
    next_st    = state_q;
    set_exc    = 1'b0;
    exc_code_d = exc_code_q;
    pc_we_c    = 1'b0;
    ir_we_c    = 1'b0;
    mw_c       = 1'b0;
    rw_c       = 1'b0;
    fs_c       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (cnt_q == MEM_LAST) begin
          pc_we_c = 1'b1;
          ir_we_c = 1'b1;
          next_st = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (dec.cls)
          CLS_J: begin
            pc_we_c = 1'b1;
            next_st = ST_FETCH;
          end
          CLS_JAL: begin
            pc_we_c = 1'b1;
            next_st = ST_WRITEBACK;
          end
          CLS_ILLEGAL: begin
            set_exc    = 1'b1;
            exc_code_d = EXC_ILLEGAL;
            next_st    = ST_EXCEPTION;
          end
          default: next_st = ST_EXECUTE;
        endcase
      end
      ST_EXECUTE: begin
        case (dec.cls)
          CLS_ALU: begin
            if (dec.ovf_chk && overflow_flag) begin
              set_exc    = 1'b1;
              exc_code_d = EXC_OVF;
              next_st    = ST_EXCEPTION;
            end else begin
              next_st = ST_WRITEBACK;
            end
          end
          CLS_LW, CLS_SW: next_st = ST_MEMORY;
          CLS_BEQ: begin
            pc_we_c = zero_flag;
            next_st = ST_FETCH;
          end
          CLS_MULT: begin
            fs_c    = 1'b1;
            next_st = ST_WAIT_FU;
          end
          CLS_DIV: begin
            if (div_zero) begin
              set_exc    = 1'b1;
              exc_code_d = EXC_DIV0;
              next_st    = ST_EXCEPTION;
            end else begin
              fs_c    = 1'b1;
              next_st = ST_WAIT_FU;
            end
          end
          default: next_st = ST_FETCH;
        endcase
      end
      ST_MEMORY: begin
        if (cnt_q == MEM_LAST) begin
          if (dec.cls == CLS_SW) begin
            mw_c    = 1'b1;
            next_st = ST_FETCH;
          end else if (dec.cls == CLS_LW) begin
            next_st = ST_WRITEBACK;
          end else begin
            next_st = ST_FETCH;
          end
        end
      end
      // Completion beats timeout when both land on the same cycle.
      ST_WAIT_FU: begin
        if (fu_done) begin
          next_st = ST_FETCH;
        end else if (cnt_q == FU_LAST) begin
          set_exc    = 1'b1;
          exc_code_d = EXC_FU_TO;
          next_st    = ST_EXCEPTION;
        end
      end
      ST_WRITEBACK: begin
        rw_c    = 1'b1;
        next_st = ST_FETCH;
      end
      ST_EXCEPTION: begin
        pc_we_c = 1'b1;
        next_st = ST_FETCH;
      end
      default: next_st = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      state_q    <= ST_FETCH;
      cnt_q      <= '0;
      exc_code_q <= EXC_ILLEGAL;
    end else if (!stall) begin
      state_q <= next_st;
      if (next_st != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (set_exc) begin
        exc_code_q <= exc_code_d;
      end
    end
  end

  // Strobes are held off while stalled so the pending one fires on release.
  assign active            = reset_in && !stall;
  assign pc_write_enable   = active && pc_we_c;
  assign instruction_write = active && ir_we_c;
  assign memory_write      = active && mw_c;
  assign register_write    = active && rw_c;
  assign fu_start          = active && fs_c;
  assign exception_valid   = reset_in && (state_q == ST_EXCEPTION);
  assign current_state     = state_q;
  assign counter           = cnt_q;
  assign exception_control = exc_code_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: two instances (MEM_LAT=1 and
// MEM_LAT=3/FU_TIMEOUT=4) share stimulus; the selected one is checked each cycle.
module tb_multicycle_sequencer;
  import seq_pkg::*;

  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_FETCH = 6'b110000;
  localparam logic [5:0] S_PC    = 6'b100000;
  localparam logic [5:0] S_MW    = 6'b001000;
  localparam logic [5:0] S_RW    = 6'b000100;
  localparam logic [5:0] S_FS    = 6'b000010;
  localparam logic [5:0] S_EXC   = 6'b100001;

  localparam logic [31:0] I_ADDI = 32'h20010001;
  localparam logic [31:0] I_LW   = 32'h8C010000;
  localparam logic [31:0] I_SW   = 32'hAC010000;
  localparam logic [31:0] I_MULT = 32'h00220018;
  localparam logic [31:0] I_DIV  = 32'h0022001A;
  localparam logic [31:0] I_ADD  = 32'h00220820;
  localparam logic [31:0] I_AND  = 32'h00221024;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_BAD  = 32'hFC000000;

  logic        clk = 1'b0;
  logic        reset_in = 1'b0;
  logic [31:0] instruction = I_ADDI;
  logic        zero_flag = 1'b0, overflow_flag = 1'b0, div_zero = 1'b0;
  logic        fu_done = 1'b0, stall = 1'b0;
  logic        sel = 1'b0;

  logic [2:0] a_st, b_st;
  logic [5:0] a_cnt, b_cnt;
  logic       a_pc, a_ir, a_mw, a_rw, a_fs, a_ev;
  logic       b_pc, b_ir, b_mw, b_rw, b_fs, b_ev;
  logic [1:0] a_ec, b_ec;
  logic [16:0] obs_a, obs_b;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;
  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_LAT(1), .FU_TIMEOUT(34), .CNT_W(6)) dut_a (
    .clk(clk), .reset_in(reset_in), .instruction(instruction),
    .zero_flag(zero_flag), .overflow_flag(overflow_flag), .div_zero(div_zero),
    .fu_done(fu_done), .stall(stall), .current_state(a_st), .counter(a_cnt),
    .pc_write_enable(a_pc), .instruction_write(a_ir), .memory_write(a_mw),
    .register_write(a_rw), .fu_start(a_fs), .exception_valid(a_ev),
    .exception_control(a_ec)
  );

  multicycle_sequencer #(.MEM_LAT(3), .FU_TIMEOUT(4), .CNT_W(6)) dut_b (
    .clk(clk), .reset_in(reset_in), .instruction(instruction),
    .zero_flag(zero_flag), .overflow_flag(overflow_flag), .div_zero(div_zero),
    .fu_done(fu_done), .stall(stall), .current_state(b_st), .counter(b_cnt),
    .pc_write_enable(b_pc), .instruction_write(b_ir), .memory_write(b_mw),
    .register_write(b_rw), .fu_start(b_fs), .exception_valid(b_ev),
    .exception_control(b_ec)
  );

  assign obs_a = {a_st, a_cnt, a_pc, a_ir, a_mw, a_rw, a_fs, a_ev, a_ec};
  assign obs_b = {b_st, b_cnt, b_pc, b_ir, b_mw, b_rw, b_fs, b_ev, b_ec};

  task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%0d cnt=%0d stb=%b ec=%0d, expected st=%0d cnt=%0d stb=%b ec=%0d",
               tag, got[16:14], got[13:8], got[7:2], got[1:0],
               exp[16:14], exp[13:8], exp[7:2], exp[1:0]);
    end
  endtask

  // Stimulus is already applied; push the expectation, compare on negedge.
  task automatic cyc(input string tag, input logic [2:0] st, input int cnt,
                     input logic [5:0] stb, input logic [1:0] ec);
    exp_t e;
    e.tag = tag;
    e.v   = {st, 6'(cnt), stb, ec};
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check_eq(e.tag, sel ? obs_b : obs_a, e.v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_in = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", ST_FETCH, 0, S_NONE, 2'd0);
    reset_in = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // ---------------- instance A: MEM_LAT=1, FU_TIMEOUT=34
    sel = 1'b0;
    do_reset();
    instruction = I_ADDI;
    cyc("addi_f",  ST_FETCH,     0, S_FETCH, 0);
    cyc("addi_d",  ST_DECODE,    0, S_NONE,  0);
    cyc("addi_e",  ST_EXECUTE,   0, S_NONE,  0);
    cyc("addi_wb", ST_WRITEBACK, 0, S_RW,    0);

    instruction = I_MULT;
    cyc("mult_f", ST_FETCH,   0, S_FETCH, 0);
    cyc("mult_d", ST_DECODE,  0, S_NONE,  0);
    cyc("mult_e", ST_EXECUTE, 0, S_FS,    0);
    for (int i = 0; i < 5; i++) cyc("mult_wait", ST_WAIT_FU, i, S_NONE, 0);
    fu_done = 1'b1;
    cyc("mult_done", ST_WAIT_FU, 5, S_NONE, 0);
    fu_done = 1'b0;

    instruction = I_BAD;
    cyc("bad_f", ST_FETCH,     0, S_FETCH, 0);
    cyc("bad_d", ST_DECODE,    0, S_NONE,  0);
    cyc("bad_x", ST_EXCEPTION, 0, S_EXC,   0);

    instruction = I_BEQ;
    zero_flag = 1'b1;
    cyc("beq1_f", ST_FETCH,   0, S_FETCH, 0);
    cyc("beq1_d", ST_DECODE,  0, S_NONE,  0);
    cyc("beq1_e", ST_EXECUTE, 0, S_PC,    0);
    zero_flag = 1'b0;
    cyc("beq0_f", ST_FETCH,   0, S_FETCH, 0);
    cyc("beq0_d", ST_DECODE,  0, S_NONE,  0);
    cyc("beq0_e", ST_EXECUTE, 0, S_NONE,  0);

    instruction = I_J;
    cyc("j_f", ST_FETCH,  0, S_FETCH, 0);
    cyc("j_d", ST_DECODE, 0, S_PC,    0);

    instruction = I_SW;
    cyc("swa_f", ST_FETCH,   0, S_FETCH, 0);
    cyc("swa_d", ST_DECODE,  0, S_NONE,  0);
    cyc("swa_e", ST_EXECUTE, 0, S_NONE,  0);
    cyc("swa_m", ST_MEMORY,  0, S_MW,    0);

    instruction = I_JAL;
    cyc("jal_f",  ST_FETCH,     0, S_FETCH, 0);
    cyc("jal_d",  ST_DECODE,    0, S_PC,    0);
    cyc("jal_wb", ST_WRITEBACK, 0, S_RW,    0);

    instruction = I_AND;
    cyc("and_f", ST_FETCH,   0, S_FETCH, 0);
    cyc("and_d", ST_DECODE,  0, S_NONE,  0);
    overflow_flag = 1'b1;
    cyc("and_e_ovf_ignored", ST_EXECUTE, 0, S_NONE, 0);
    overflow_flag = 1'b0;
    cyc("and_wb", ST_WRITEBACK, 0, S_RW, 0);

    instruction = I_ADD;
    cyc("add_f", ST_FETCH,  0, S_FETCH, 0);
    cyc("add_d", ST_DECODE, 0, S_NONE,  0);
    overflow_flag = 1'b1;
    cyc("add_e_ovf", ST_EXECUTE, 0, S_NONE, 0);
    overflow_flag = 1'b0;
    cyc("add_x", ST_EXCEPTION, 0, S_EXC, 1);

    instruction = I_DIV;
    cyc("div_f", ST_FETCH,  0, S_FETCH, 1);
    cyc("div_d", ST_DECODE, 0, S_NONE,  1);
    div_zero = 1'b1;
    cyc("div_e_dz", ST_EXECUTE, 0, S_NONE, 1);
    div_zero = 1'b0;
    cyc("div_x", ST_EXCEPTION, 0, S_EXC, 2);

    instruction = I_MULT;
    cyc("mrst_f", ST_FETCH,   0, S_FETCH, 2);
    cyc("mrst_d", ST_DECODE,  0, S_NONE,  2);
    cyc("mrst_e", ST_EXECUTE, 0, S_FS,    2);
    cyc("mrst_w0", ST_WAIT_FU, 0, S_NONE, 2);
    cyc("mrst_w1", ST_WAIT_FU, 1, S_NONE, 2);
    reset_in = 1'b0;
    stall    = 1'b1;
    cyc("mrst_w2_rst_low", ST_WAIT_FU, 2, S_NONE, 2);
    cyc("mrst_after_rst",  ST_FETCH,   0, S_NONE, 0);
    reset_in = 1'b1;
    stall    = 1'b0;
    cyc("mrst_release", ST_FETCH, 0, S_FETCH, 0);

    // ---------------- instance B: MEM_LAT=3, FU_TIMEOUT=4
    sel = 1'b1;
    do_reset();
    instruction = I_LW;
    for (int i = 0; i < 2; i++) cyc("lw_f", ST_FETCH, i, S_NONE, 0);
    cyc("lw_f_last", ST_FETCH,   2, S_FETCH, 0);
    cyc("lw_d",      ST_DECODE,  0, S_NONE,  0);
    cyc("lw_e",      ST_EXECUTE, 0, S_NONE,  0);
    for (int i = 0; i < 3; i++) cyc("lw_m", ST_MEMORY, i, S_NONE, 0);
    cyc("lw_wb", ST_WRITEBACK, 0, S_RW, 0);

    instruction = I_MULT;
    for (int i = 0; i < 2; i++) cyc("to_f", ST_FETCH, i, S_NONE, 0);
    cyc("to_f_last", ST_FETCH,   2, S_FETCH, 0);
    cyc("to_d",      ST_DECODE,  0, S_NONE,  0);
    cyc("to_e",      ST_EXECUTE, 0, S_FS,    0);
    for (int i = 0; i < 4; i++) cyc("to_wait", ST_WAIT_FU, i, S_NONE, 0);
    cyc("to_x", ST_EXCEPTION, 0, S_EXC, 3);

    for (int i = 0; i < 2; i++) cyc("tie_f", ST_FETCH, i, S_NONE, 3);
    cyc("tie_f_last", ST_FETCH,   2, S_FETCH, 3);
    cyc("tie_d",      ST_DECODE,  0, S_NONE,  3);
    cyc("tie_e",      ST_EXECUTE, 0, S_FS,    3);
    for (int i = 0; i < 3; i++) cyc("tie_wait", ST_WAIT_FU, i, S_NONE, 3);
    fu_done = 1'b1;
    cyc("tie_done_at_limit", ST_WAIT_FU, 3, S_NONE, 3);
    fu_done = 1'b0;
    cyc("tie_back_fetch", ST_FETCH, 0, S_NONE, 3);

    instruction = I_ADDI;
    cyc("stall_f1", ST_FETCH, 1, S_NONE, 3);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc("stall_hold", ST_FETCH, 2, S_NONE, 3);
    stall = 1'b0;
    cyc("stall_release", ST_FETCH,     2, S_FETCH, 3);
    cyc("stall_d",       ST_DECODE,    0, S_NONE,  3);
    cyc("stall_e",       ST_EXECUTE,   0, S_NONE,  3);
    cyc("stall_wb",      ST_WRITEBACK, 0, S_RW,    3);

    instruction = I_SW;
    for (int i = 0; i < 2; i++) cyc("swb_f", ST_FETCH, i, S_NONE, 3);
    cyc("swb_f_last", ST_FETCH,   2, S_FETCH, 3);
    cyc("swb_d",      ST_DECODE,  0, S_NONE,  3);
    cyc("swb_e",      ST_EXECUTE, 0, S_NONE,  3);
    for (int i = 0; i < 2; i++) cyc("swb_m", ST_MEMORY, i, S_NONE, 3);
    cyc("swb_m_last", ST_MEMORY, 2, S_MW,   3);
    cyc("swb_back",   ST_FETCH,  0, S_NONE, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
